// File: rtl/fp_addsub_pipe.sv
// Four-stage floating-point add/subtract (result = ay +/- ax) with round-to-nearest-even.
// Subnormals flush to zero; NaN/inf/overflow handled with per-result flags aligned to result.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int DW = 1 + EXP_W + MAN_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          clr,
  input  logic          in_valid,
  input  logic          op_sub,
  input  logic [DW-1:0] ax,
  input  logic [DW-1:0] ay,
  output logic          out_valid,
  output logic [DW-1:0] result,
  output logic          flag_ovf,
  output logic          flag_inv
);

  localparam int XW  = MAN_W + 4;          // hidden + mantissa + guard/round/sticky
  localparam int SW  = MAN_W + 5;          // XW plus carry
  localparam int LZW = $clog2(SW + 1);
  localparam int EW  = EXP_W + 2;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [DW-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [EW-1:0] E_MAX = EW'(2**EXP_W - 1);

  typedef struct packed {
    logic             vld;
    logic             spc;
    logic             inv;
    logic [DW-1:0]    spc_res;
    logic             sign;
    logic             eff_sub;
    logic [EXP_W-1:0] exp_a;
    logic [EXP_W-1:0] diff;
    logic [MAN_W:0]   sig_a;
    logic [MAN_W:0]   sig_b;
  } s1_t;

  typedef struct packed {
    logic             vld;
    logic             spc;
    logic             inv;
    logic [DW-1:0]    spc_res;
    logic             sign;
    logic             eff_sub;
    logic [EXP_W-1:0] exp_a;
    logic [XW-1:0]    ma;
    logic [XW-1:0]    mb;
  } s2_t;

  typedef struct packed {
    logic             vld;
    logic             spc;
    logic             inv;
    logic [DW-1:0]    spc_res;
    logic             sign;
    logic [EXP_W-1:0] exp_a;
    logic [SW-1:0]    sum;
    logic [LZW-1:0]   lz;
  } s3_t;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;

  function automatic logic [LZW-1:0] lzc(input logic [SW-1:0] v);
    lzc = LZW'(SW);
    for (int i = 0; i < SW; i++) begin
      if (v[i]) lzc = LZW'(SW - 1 - i);
    end
  endfunction

  // S1: unpack, flush subnormals, order by magnitude, detect specials
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             nan_a, nan_b, inf_a, inf_b, swap;

  always_comb begin
    sa    = ay[DW-1];
    ea    = ay[DW-2:MAN_W];
    fa    = (ea == '0) ? '0 : ay[MAN_W-1:0];
    sb    = ax[DW-1] ^ op_sub;
    eb    = ax[DW-2:MAN_W];
    fb    = (eb == '0) ? '0 : ax[MAN_W-1:0];
    nan_a = (ea == EXP_ONES) && (fa != '0);
    nan_b = (eb == EXP_ONES) && (fb != '0);
    inf_a = (ea == EXP_ONES) && (fa == '0);
    inf_b = (eb == EXP_ONES) && (fb == '0);
    swap  = {eb, fb} > {ea, fa};

    s1_d         = '0;
    s1_d.vld     = in_valid;
    s1_d.eff_sub = sa ^ sb;
    if (swap) begin
      s1_d.sign  = sb;
      s1_d.exp_a = eb;
      s1_d.diff  = eb - ea;
      s1_d.sig_a = {(eb != '0), fb};
      s1_d.sig_b = {(ea != '0), fa};
    end else begin
      s1_d.sign  = sa;
      s1_d.exp_a = ea;
      s1_d.diff  = ea - eb;
      s1_d.sig_a = {(ea != '0), fa};
      s1_d.sig_b = {(eb != '0), fb};
    end

    if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
      s1_d.spc     = 1'b1;
      s1_d.inv     = 1'b1;
      s1_d.spc_res = QNAN;
    end else if (inf_a) begin
      s1_d.spc     = 1'b1;
      s1_d.spc_res = {sa, EXP_ONES, {MAN_W{1'b0}}};
    end else if (inf_b) begin
      s1_d.spc     = 1'b1;
      s1_d.spc_res = {sb, EXP_ONES, {MAN_W{1'b0}}};
    end else if ((ea == '0) && (eb == '0)) begin
      s1_d.spc     = 1'b1;
      s1_d.spc_res = {sa & sb, {(DW-1){1'b0}}};
    end
  end

  // S2: align B to A, folding shifted-out bits into sticky
  logic [2*XW-1:0] wide;

  always_comb begin
    s2_d         = '0;
    s2_d.vld     = s1_q.vld;
    s2_d.spc     = s1_q.spc;
    s2_d.inv     = s1_q.inv;
    s2_d.spc_res = s1_q.spc_res;
    s2_d.sign    = s1_q.sign;
    s2_d.eff_sub = s1_q.eff_sub;
    s2_d.exp_a   = s1_q.exp_a;
    s2_d.ma      = {s1_q.sig_a, 3'b000};
    wide         = '0;
    if (int'(s1_q.diff) >= MAN_W + 3) begin
      s2_d.mb = {{(XW-1){1'b0}}, |s1_q.sig_b};
    end else begin
      wide    = {s1_q.sig_b, 3'b000, {XW{1'b0}}} >> s1_q.diff;
      s2_d.mb = {wide[2*XW-1:XW+1], wide[XW] | (|wide[XW-1:0])};
    end
  end

  // S3: magnitude add/subtract; A >= B so the difference never goes negative
  always_comb begin
    s3_d         = '0;
    s3_d.vld     = s2_q.vld;
    s3_d.spc     = s2_q.spc;
    s3_d.inv     = s2_q.inv;
    s3_d.spc_res = s2_q.spc_res;
    s3_d.sign    = s2_q.sign;
    s3_d.exp_a   = s2_q.exp_a;
    s3_d.sum     = s2_q.eff_sub ? ({1'b0, s2_q.ma} - {1'b0, s2_q.mb})
                                : ({1'b0, s2_q.ma} + {1'b0, s2_q.mb});
    s3_d.lz      = lzc(s3_d.sum);
  end

  // S4: normalise (leading one moves to the dropped top bit), round, range check, pack
  logic [XW-1:0]          norm;
  logic [MAN_W-1:0]       frac_r;
  logic                   rc, rup;
  logic signed [EW-1:0]   e_res;
  logic [DW-1:0]          res_d;
  logic                   ovf_d, inv_d;

  always_comb begin
    norm         = s3_q.sum[SW-2:0] << s3_q.lz;
    rup          = norm[3] & ((|norm[2:0]) | norm[4]);
    {rc, frac_r} = {1'b0, norm[XW-1:4]} + (MAN_W+1)'(rup);
    e_res        = $signed(EW'(s3_q.exp_a)) + $signed(EW'(1)) - $signed(EW'(s3_q.lz))
                 + $signed(EW'(rc));
    res_d        = '0;
    ovf_d        = 1'b0;
    inv_d        = 1'b0;
    if (s3_q.spc) begin
      res_d = s3_q.spc_res;
      inv_d = s3_q.inv;
    end else if (s3_q.sum == '0) begin
      res_d = '0;
    end else if (e_res >= E_MAX) begin
      res_d = {s3_q.sign, EXP_ONES, {MAN_W{1'b0}}};
      ovf_d = 1'b1;
    end else if (e_res <= $signed(EW'(0))) begin
      res_d = '0;
    end else begin
      res_d = {s3_q.sign, e_res[EXP_W-1:0], frac_r};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else if (ena) begin
      s1_q <= clr ? '0 : s1_d;
      s2_q <= clr ? '0 : s2_d;
      s3_q <= clr ? '0 : s3_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flag_ovf  <= 1'b0;
      flag_inv  <= 1'b0;
    end else if (ena) begin
      if (clr) begin
        out_valid <= 1'b0;
        result    <= '0;
        flag_ovf  <= 1'b0;
        flag_inv  <= 1'b0;
      end else begin
        out_valid <= s3_q.vld;
        result    <= res_d;
        flag_ovf  <= ovf_d;
        flag_inv  <= inv_d;
      end
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe: exact-arithmetic reference model behind a 4-edge delay line.
module tb_fp_addsub_pipe;

  logic        clk = 1'b0, rst_n = 1'b1, ena = 1'b0, clr = 1'b0;
  logic        in_valid = 1'b0, op_sub = 1'b0;
  logic [31:0] ax = 32'h0, ay = 32'h0;
  logic        out_valid, flag_ovf, flag_inv;
  logic [31:0] result;
  int          checks = 0, failures = 0;

  always #5 clk = ~clk;

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr), .in_valid(in_valid),
    .op_sub(op_sub), .ax(ax), .ay(ay), .out_valid(out_valid), .result(result),
    .flag_ovf(flag_ovf), .flag_inv(flag_inv)
  );

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Exact value of ay +/- ax as a wide integer, then one RNE rounding. Returns {inv, ovf, result}.
  function automatic logic [33:0] ref_op(input logic [31:0] y, input logic [31:0] x, input logic op);
    logic sy, sx, s, g, st;
    int ey, ex, emin, p, sh, e;
    logic [22:0] my, mx;
    logic [299:0] vy, vx, mag, msk;
    logic [24:0] sig;
    sy = y[31]; ey = int'(y[30:23]); my = (ey == 0) ? 23'd0 : y[22:0];
    sx = x[31] ^ op; ex = int'(x[30:23]); mx = (ex == 0) ? 23'd0 : x[22:0];
    if ((ey == 255 && my != 0) || (ex == 255 && mx != 0)) return {2'b10, 32'h7FC00000};
    if (ey == 255 && ex == 255) return (sy != sx) ? {2'b10, 32'h7FC00000} : {2'b00, sy, 8'hFF, 23'd0};
    if (ey == 255) return {2'b00, sy, 8'hFF, 23'd0};
    if (ex == 255) return {2'b00, sx, 8'hFF, 23'd0};
    if (ey == 0 && ex == 0) return {2'b00, sy & sx, 31'd0};
    emin = (ey == 0) ? ex : (ex == 0) ? ey : ((ey < ex) ? ey : ex);
    vy = (ey == 0) ? 300'd0 : (300'({1'b1, my}) << (ey - emin));
    vx = (ex == 0) ? 300'd0 : (300'({1'b1, mx}) << (ex - emin));
    if (sy == sx) begin mag = vy + vx; s = sy; end
    else if (vy >= vx) begin mag = vy - vx; s = sy; end
    else begin mag = vx - vy; s = sx; end
    if (mag == 300'd0) return 34'd0;
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    e = emin + p - 23;
    if (p > 23) begin
      sh  = p - 23;
      sig = 25'(mag >> sh);
      g   = mag[sh-1];
      msk = (300'd1 << (sh - 1)) - 300'd1;
      st  = |(mag & msk);
      if (g && (st || sig[0])) sig = sig + 25'd1;
      if (sig[24]) begin sig = sig >> 1; e++; end
    end else begin
      sig = 25'(mag << (23 - p));
    end
    if (e >= 255) return {2'b01, s, 8'hFF, 23'd0};
    if (e <= 0) return 34'd0;
    return {2'b00, s, 8'(e), sig[22:0]};
  endfunction

  typedef struct packed {
    logic        v;
    logic        inv;
    logic        ovf;
    logic [31:0] r;
  } exp_t;
  exp_t pipe [4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) pipe[i] <= '0;
    end else if (ena) begin
      if (clr) begin
        for (int i = 0; i < 4; i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= {in_valid, ref_op(ay, ax, op_sub)};
        for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("out_valid", 34'(out_valid), 34'(pipe[3].v));
    chk("result",    34'(result),    34'(pipe[3].r));
    chk("flag_ovf",  34'(flag_ovf),  34'(pipe[3].ovf));
    chk("flag_inv",  34'(flag_inv),  34'(pipe[3].inv));
  end

  task automatic drive(input logic v, input logic o, input logic [31:0] y, input logic [31:0] x);
    @(negedge clk);
    in_valid = v; op_sub = o; ay = y; ax = x;
  endtask

  function automatic logic [31:0] special_val();
    case ($urandom_range(0, 9))
      0: return 32'h00000000;
      1: return 32'h80000000;
      2: return 32'h7F800000;
      3: return 32'hFF800000;
      4: return 32'h7FC00000;
      5: return 32'h00000001;
      6: return 32'h7F7FFFFF;
      7: return 32'hFF7FFFFF;
      8: return 32'h00800000;
      default: return 32'h3F800000;
    endcase
  endfunction

  function automatic logic [31:0] rnd_y();
    if ($urandom_range(0, 15) == 0) return special_val();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
  endfunction

  function automatic logic [31:0] rnd_x(input logic [31:0] y);
    int m, e;
    m = $urandom_range(0, 7);
    if (m < 4) begin
      e = int'(y[30:23]) + int'($urandom_range(0, 60)) - 30;
      if (e < 1) e = 1;
      if (e > 254) e = 254;
      return {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
    end
    if (m < 6) return $urandom;
    if (m == 6) return special_val();
    return {1'($urandom_range(0, 1)), y[30:4], 4'($urandom)};
  endfunction

  initial begin
    // Pin the reference model to hand-computed results
    chk("model_sub0", ref_op(32'h41668F5C, 32'h41591270, 1'b1), {2'b00, 32'h3F57CEC0});
    chk("model_sub1", ref_op(32'h414153F8, 32'h41439DB4, 1'b1), {2'b00, 32'hBE126F00});
    chk("model_sub2", ref_op(32'h416974BC, 32'h414D0624, 1'b1), {2'b00, 32'h3FE374C0});
    chk("model_add",  ref_op(32'h3F800000, 32'h3F800000, 1'b0), {2'b00, 32'h40000000});
    chk("model_tie",  ref_op(32'h3F800000, 32'h33800000, 1'b0), {2'b00, 32'h3F800000});
    chk("model_rup",  ref_op(32'h3F800000, 32'h33C00000, 1'b0), {2'b00, 32'h3F800001});
    chk("model_canc", ref_op(32'h3F800000, 32'h3F800000, 1'b1), {2'b00, 32'h00000000});
    chk("model_inv",  ref_op(32'h7F800000, 32'h7F800000, 1'b1), {2'b10, 32'h7FC00000});
    chk("model_ovf",  ref_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0), {2'b01, 32'h7F800000});
    chk("model_sub",  ref_op(32'h00000001, 32'h3F800000, 1'b0), {2'b00, 32'h3F800000});
    chk("model_zneg", ref_op(32'h00000000, 32'h3F800000, 1'b1), {2'b00, 32'hBF800000});

    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid",  34'(out_valid), 34'd0);
    chk("rst_result", 34'(result),    34'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    ena = 1'b1; clr = 1'b1;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 32'h41668F5C, 32'h41591270);
    @(negedge clk);
    clr = 1'b0;

    drive(1'b1, 1'b1, 32'h41668F5C, 32'h41591270);
    drive(1'b1, 1'b1, 32'h414153F8, 32'h41439DB4);
    drive(1'b1, 1'b1, 32'h416974BC, 32'h414D0624);
    drive(1'b1, 1'b0, 32'h3F800000, 32'h3F800000);
    drive(1'b1, 1'b0, 32'h3F800000, 32'h33800000);
    drive(1'b1, 1'b0, 32'h3F800000, 32'h33C00000);
    drive(1'b1, 1'b1, 32'h3F800000, 32'h3F800000);
    drive(1'b1, 1'b1, 32'h7F800000, 32'h7F800000);
    drive(1'b1, 1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF);
    drive(1'b1, 1'b0, 32'h00000001, 32'h3F800000);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (5) drive(1'b0, 1'b0, 32'h0, 32'h0);

    // Stall with three ops in flight; stalled inputs must not be captured
    drive(1'b1, 1'b0, 32'h40400000, 32'h3F800000);
    drive(1'b1, 1'b1, 32'h40400000, 32'h3F800000);
    drive(1'b1, 1'b0, 32'hC0A00000, 32'h40000000);
    @(negedge clk);
    ena = 1'b0; in_valid = 1'b1; ay = 32'h12345678; ax = 32'h9ABCDEF0;
    repeat (5) @(negedge clk);
    ena = 1'b1;
    repeat (5) drive(1'b0, 1'b0, 32'h0, 32'h0);

    // Flush with two ops in flight
    drive(1'b1, 1'b0, 32'h3F800000, 32'h40000000);
    drive(1'b1, 1'b0, 32'h40000000, 32'h40000000);
    @(negedge clk);
    in_valid = 1'b0; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (5) drive(1'b0, 1'b0, 32'h0, 32'h0);

    // Async reset with a full pipeline, then first op after release
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 32'h3F800000, 32'h3F800000);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid",  34'(out_valid), 34'd0);
    chk("arst_result", 34'(result),    34'd0);
    chk("arst_flags",  34'({flag_ovf, flag_inv}), 34'd0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; op_sub = 1'b0; ay = 32'h3F800000; ax = 32'h3F800000;
    @(negedge clk);
    in_valid = 1'b0; ay = 32'h0; ax = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("relat_early", 34'(out_valid), 34'd0);
    @(posedge clk);
    #1;
    chk("relat_valid",  34'(out_valid), 34'd1);
    chk("relat_result", 34'(result),    34'(32'h40000000));

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      ena      = ($urandom_range(0, 9) != 0);
      clr      = ($urandom_range(0, 39) == 0);
      in_valid = ($urandom_range(0, 4) != 0);
      op_sub   = 1'($urandom_range(0, 1));
      ay       = rnd_y();
      ax       = rnd_x(ay);
    end
    @(negedge clk);
    ena = 1'b1; clr = 1'b0;
    repeat (6) drive(1'b0, 1'b0, 32'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
